// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
//   state_t          : receive FSM states (idle between frames / shifting a frame)
//   SIPO_DEF_WIDTH   : default data word width
//   sipo_frame_len() : serial frame length for a given word width
// Optional feature macro: SIPO_PARITY_EN (frame carries a trailing even-parity bit).
package sipo_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_t;

  localparam int unsigned SIPO_DEF_WIDTH = 8;

  // One serial frame is the data word, plus the parity bit when enabled.
  function automatic int unsigned sipo_frame_len(input int unsigned width);
`ifdef SIPO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter for the deserializer.
// Counts enabled clocks within a frame and wraps to zero after the last bit.
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   en_i       : count this edge
//   clr_i      : synchronous clear, priority over en_i
//   cnt_o      : bits collected so far in the current frame
//   last_bit_o : the bit sampled this edge (if enabled) completes the frame
module sipo_bit_counter #(
  parameter int unsigned Frame = 8,
  parameter int unsigned CntW  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            last_bit_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_bit_o = (cnt_q == CntW'(Frame - 1));
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_bit_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver, LSB first, with valid/ready output handshake.
// Optional feature macro: SIPO_PARITY_EN (adds a trailing even-parity bit per frame and
// drives parity_err_o; otherwise parity_err_o is tied low).
// Ports:
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   en_i         : sample sin_i on this edge
//   sin_i        : serial data in
//   clr_i        : synchronous frame abort; drops partial frame and clears overrun
//   dout_o       : last completed word
//   dout_valid_o : dout_o holds an unconsumed word
//   dout_ready_i : consumer accepts dout_o this cycle
//   bit_cnt_o    : bits collected in the current frame
//   busy_o       : partial frame in progress
//   overrun_o    : sticky, a completed word replaced an unconsumed one
//   parity_err_o : parity of last completed frame was odd
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned Width = SIPO_DEF_WIDTH,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sin_i,
  input  logic             clr_i,
  output logic [Width-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic [CntW-1:0]  bit_cnt_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  localparam int unsigned Frame = sipo_frame_len(Width);
  // The final bit of a frame goes straight to the output register, so the shift
  // register only needs to hold the bits sampled before it.
  localparam int unsigned ShW   = Frame - 1;

  state_t           state_q;
  logic [ShW-1:0]   shreg_q, shreg_d;
  logic [Width-1:0] dout_q, word;
  logic             valid_q, overrun_q;
  logic [CntW-1:0]  bit_cnt;
  logic             last_bit;
  logic             sample;
  logic             complete;

  assign sample   = en_i && !clr_i;
  assign complete = sample && last_bit;

  sipo_bit_counter #(
    .Frame (Frame),
    .CntW  (CntW)
  ) u_bit_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .cnt_o      (bit_cnt),
    .last_bit_o (last_bit)
  );

`ifdef SIPO_PARITY_EN
  // Last bit is the parity bit; the data word is entirely in the shift register.
  assign word = shreg_q;
`else
  assign word = {sin_i, shreg_q};
`endif

  always_comb begin
    shreg_d = shreg_q;
    if (clr_i || complete) begin
      shreg_d = '0;
    end else if (sample) begin
      for (int i = 0; i < int'(ShW); i++) begin
        if (bit_cnt == CntW'(i)) begin
          shreg_d[i] = sin_i;
        end
      end
    end
  end

  // Receive FSM: StIdle exactly when no bits of a frame are held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else if (clr_i) begin
      state_q <= StIdle;
    end else if (en_i) begin
      state_q <= last_bit ? StIdle : StShift;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Output register and handshake. A completion always (re)asserts valid, even when
  // the consumer takes the previous word on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (complete) begin
        dout_q  <= word;
        valid_q <= 1'b1;
      end else if (valid_q && dout_ready_i) begin
        valid_q <= 1'b0;
      end

      if (clr_i) begin
        overrun_q <= 1'b0;
      end else if (complete && valid_q && !dout_ready_i) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_err_q;

  // Even parity over data plus parity bit; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_q <= 1'b0;
    end else if (complete) begin
      parity_err_q <= ^{shreg_q, sin_i};
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign bit_cnt_o    = bit_cnt;
  assign busy_o       = (state_q == StShift);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (default width 8).
// Honours SIPO_PARITY_EN when defined for the build.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
  localparam int Frame = 9;
`else
  localparam int Frame = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sin = 1'b0;
  logic       clr = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] bit_cnt;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int failures = 0;

  sipo_deserializer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .sin_i        (sin),
    .clr_i        (clr),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .bit_cnt_o    (bit_cnt),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .parity_err_o (parity_err)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send n bits of w LSB first; ready asserted only on the final edge when rdy_last.
  task automatic send_bits(input logic [7:0] w, input int n, input logic par,
                           input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      sin = (i < 8) ? w[i] : par;
      dout_ready = (i == Frame - 1) ? rdy_last : 1'b0;
      tick();
    end
    en = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({dout, dout_valid, bit_cnt, busy, overrun, parity_err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_init: got dout=%h v=%b cnt=%0d busy=%b ovr=%b perr=%b, want all 0",
               dout, dout_valid, bit_cnt, busy, overrun, parity_err);
    end
    rst_n = 1'b1;
    tick();
    send_bits(8'h05, 3, 1'b0, 1'b0);
    checks++;
    if (bit_cnt !== 4'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_cnt: got cnt=%0d busy=%b, want 3 1", bit_cnt, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, bit_cnt, busy, overrun, parity_err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_midframe: got dout=%h v=%b cnt=%0d busy=%b, want all 0",
               dout, dout_valid, bit_cnt, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_bits(8'h01, 1, 1'b0, 1'b0);
    checks++;
    if (bit_cnt !== 4'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_start: got cnt=%0d busy=%b, want 1 1", bit_cnt, busy);
    end
    // Restart cleanly for following tests.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_bits(8'hA5, Frame - 1, 1'b0, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || bit_cnt !== 4'(Frame - 1)) begin
      failures++;
      $display("FAIL basic_before_last: got v=%b cnt=%0d, want 0 %0d", dout_valid, bit_cnt,
               Frame - 1);
    end
    send_bits(8'hA5 >> (Frame - 1), 1, 1'b0, 1'b0);
    checks++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1 || bit_cnt !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_word: got dout=%h v=%b cnt=%0d busy=%b, want a5 1 0 0",
               dout, dout_valid, bit_cnt, busy);
    end
    // Idle cycles with en=0 keep the word; then consume it.
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checks++;
    if (dout !== 8'hA5 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_consume: got dout=%h v=%b, want a5 0", dout, dout_valid);
    end
  endtask

  task automatic test_overrun();
    send_bits(8'h3C, Frame, 1'b0, 1'b0);
    send_bits(8'hC3, Frame, 1'b0, 1'b0);
    checks++;
    if (dout !== 8'hC3 || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got dout=%h v=%b ovr=%b, want c3 1 1", dout, dout_valid,
               overrun);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || dout !== 8'hC3 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_clr: got ovr=%b dout=%h v=%b, want 0 c3 1", overrun, dout,
               dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    // C3 still pending; consumer takes it on the same edge 81 completes.
    send_bits(8'h81, Frame, 1'b0, 1'b1);
    checks++;
    if (dout !== 8'h81 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_ready: got dout=%h v=%b ovr=%b, want 81 1 0", dout, dout_valid,
               overrun);
    end
    // Handshake works with en=0 and a partial frame held.
    send_bits(8'h02, 2, 1'b0, 1'b0);
    dout_ready = 1'b1;
    tick();
    tick();
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || bit_cnt !== 4'd2 || busy !== 1'b1 || dout !== 8'h81) begin
      failures++;
      $display("FAIL en_low_hold: got v=%b cnt=%0d busy=%b dout=%h, want 0 2 1 81",
               dout_valid, bit_cnt, busy, dout);
    end
  endtask

  task automatic test_clr_abort();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send_bits(8'h0F, 4, 1'b0, 1'b0);
    checks++;
    if (bit_cnt !== 4'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_pre: got cnt=%0d busy=%b, want 4 1", bit_cnt, busy);
    end
    en = 1'b1;
    sin = 1'b1;
    clr = 1'b1;
    tick();
    en = 1'b0;
    clr = 1'b0;
    checks++;
    if (bit_cnt !== 4'd0 || busy !== 1'b0 || dout !== 8'h81 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_abort: got cnt=%0d busy=%b dout=%h v=%b, want 0 0 81 0", bit_cnt,
               busy, dout, dout_valid);
    end
    send_bits(8'hFF, Frame, 1'b0, 1'b0);
    checks++;
    if (dout !== 8'hFF || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL clr_next_frame: got dout=%h v=%b ovr=%b, want ff 1 0", dout, dout_valid,
               overrun);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  task automatic test_parity();
`ifdef SIPO_PARITY_EN
    send_bits(8'h07, Frame, 1'b1, 1'b1);
    checks++;
    if (parity_err !== 1'b0 || dout !== 8'h07) begin
      failures++;
      $display("FAIL parity_good: got perr=%b dout=%h, want 0 07", parity_err, dout);
    end
    send_bits(8'h07, Frame, 1'b0, 1'b1);
    checks++;
    if (parity_err !== 1'b1 || dout !== 8'h07) begin
      failures++;
      $display("FAIL parity_bad: got perr=%b dout=%h, want 1 07", parity_err, dout);
    end
`else
    send_bits(8'h07, Frame, 1'b0, 1'b1);
    checks++;
    if (parity_err !== 1'b0 || dout !== 8'h07) begin
      failures++;
      $display("FAIL parity_tied: got perr=%b dout=%h, want 0 07", parity_err, dout);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_clr_abort();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
